slice_pipe_arbiter: RTL and testbench

SLICE_PIPE_ARBITER -- requirements
Module: slice_pipe_arbiter

---
 rtl/slice_pipe_arbiter.sv | 108 ++++++++++
 tb/tb_slice_pipe_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/slice_pipe_arbiter.sv
// Round-robin arbiter feeding a two-stage slice pipe with stall, flush and reset.
// Stage 2 drives the output handshake; stage 1 captures the granted request.
module slice_pipe_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [IDW-1:0]        out_id,
    input  logic                  out_ready,
    output logic [1:0]            inflight
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [IDW-1:0]   s1_id_q,    s1_id_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q,  s2_data_d;
    logic [IDW-1:0]   s2_id_q,    s2_id_d;
    logic [IDW-1:0]   ptr_q,      ptr_d;

    logic             advance;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic             transfer;

    assign advance = !s2_valid_q || out_ready;

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int unsigned cand;
            cand = (int'(ptr_q) + k) % NREQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(cand);
            end
        end
    end

    assign transfer = grant_found && advance && !flush && !reset;

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        ptr_d      = ptr_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else if (advance) begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_data_q;
            s2_id_d    = s1_id_q;
            s1_valid_d = transfer;
            if (transfer) begin
                s1_data_d = req_data[int'(grant_idx)*WIDTH +: WIDTH];
                s1_id_d   = grant_idx;
                ptr_d     = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
            ptr_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_id    = s2_id_q;
    assign inflight  = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};

endmodule

// File: tb/tb_slice_pipe_arbiter.sv
// Randomized bench for slice_pipe_arbiter against a behavioural pipe model.
// Directed phases cover single request, round-robin, stall, wrap, flush and reset.
module tb_slice_pipe_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  flush;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [IDW-1:0]        out_id;
    logic                  out_ready;
    logic [1:0]            inflight;

    int n_vec = 0;
    int n_err = 0;

    // Model: the pipe as two slots, slot 1 being the output end.
    int m_valid [2];
    int m_data  [2];
    int m_id    [2];
    int m_ptr;
    int prev_reset;

    slice_pipe_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input int observed, input int expected);
        n_vec++;
        if (observed !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // One cycle: drive inputs, check outputs against the model, then step the model.
    task automatic apply_stimulus(input logic [NREQ-1:0] rv, input logic [NREQ*WIDTH-1:0] rd,
                                  input logic ordy, input logic fl, input logic rst);
        int adv;
        int g;
        int exp_ready;
        req_valid = rv;
        req_data  = rd;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        #1;
        adv = (m_valid[1] == 0 || ordy) ? 1 : 0;
        g = -1;
        if (adv != 0 && !fl && !rst) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (g < 0 && rv[c]) g = c;
            end
        end
        exp_ready = (g >= 0) ? (1 << g) : 0;
        check_output("req_ready", int'(req_ready), exp_ready);
        check_output("out_valid", int'(out_valid), m_valid[1]);
        check_output("inflight", int'(inflight), m_valid[0] + m_valid[1]);
        if (m_valid[1] != 0) begin
            check_output("out_data", int'(out_data), m_data[1]);
            check_output("out_id", int'(out_id), m_id[1]);
        end
        if (prev_reset != 0) begin
            check_output("reset_out_data", int'(out_data), 0);
            check_output("reset_out_id", int'(out_id), 0);
        end
        @(posedge clk);
        if (rst) begin
            m_valid = '{0, 0};
            m_data  = '{0, 0};
            m_id    = '{0, 0};
            m_ptr   = 0;
        end else if (fl) begin
            m_valid = '{0, 0};
        end else if (adv != 0) begin
            m_valid[1] = m_valid[0];
            m_data[1]  = m_data[0];
            m_id[1]    = m_id[0];
            m_valid[0] = (g >= 0) ? 1 : 0;
            if (g >= 0) begin
                m_data[0] = int'((rd >> (g * WIDTH)) & ((1 << WIDTH) - 1));
                m_id[0]   = g;
                m_ptr     = (g + 1) % NREQ;
            end
        end
        prev_reset = rst ? 1 : 0;
        @(negedge clk);
    endtask

    initial begin
        m_valid    = '{0, 0};
        m_data     = '{0, 0};
        m_id       = '{0, 0};
        m_ptr      = 0;
        prev_reset = 0;
        req_valid  = '0;
        req_data   = '0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        apply_stimulus('0, '0, 1'b1, 1'b0, 1'b1);
        apply_stimulus(4'b1111, 32'h11223344, 1'b1, 1'b0, 1'b1);

        // Single request from requester 2, then drain.
        apply_stimulus(4'b0100, 32'h00A50000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus('0, '0, 1'b1, 1'b0, 1'b0);

        // All requesting: grants rotate, one per cycle.
        for (int i = 0; i < 8; i++) apply_stimulus(4'b1111, $urandom, 1'b1, 1'b0, 1'b0);

        // Stall with two in flight, then drain.
        for (int i = 0; i < 3; i++) apply_stimulus(4'b1111, $urandom, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus('0, '0, 1'b1, 1'b0, 1'b0);

        // Wrap: move ptr to 3, then requesters 0 and 1 only.
        apply_stimulus(4'b0100, $urandom, 1'b1, 1'b0, 1'b0);
        apply_stimulus(4'b0011, $urandom, 1'b1, 1'b0, 1'b0);
        apply_stimulus(4'b0011, $urandom, 1'b1, 1'b0, 1'b0);

        // Flush with pipe full; ptr must survive.
        apply_stimulus(4'b1111, $urandom, 1'b1, 1'b1, 1'b0);
        apply_stimulus(4'b1111, $urandom, 1'b1, 1'b0, 1'b0);
        apply_stimulus(4'b1111, $urandom, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream; next grant must come from requester 0.
        apply_stimulus(4'b1111, $urandom, 1'b1, 1'b0, 1'b1);
        apply_stimulus(4'b1111, $urandom, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            apply_stimulus(NREQ'($urandom_range(0, (1 << NREQ) - 1)), $urandom,
                           $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
                           $urandom_range(0, 79) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
